// File: rtl/con_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : con_loader_pkg
// Description : Shared types and constants for the console-port loader.
//               The verify states exist only when CON_LOADER_VERIFY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package con_loader_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_HDR        = 4'd1,
        ST_WR_COLLECT = 4'd2,
        ST_WR_COMMIT  = 4'd3,
        ST_RD_ISSUE   = 4'd4,
        ST_RD_WAIT    = 4'd5,
        ST_RD_SEND    = 4'd6,
        ST_ACK        = 4'd7
`ifdef CON_LOADER_VERIFY_EN
        ,
        ST_VFY_ISSUE  = 4'd8,
        ST_VFY_WAIT   = 4'd9
`endif
    } state_e;

    localparam logic [7:0] C_ACK_BYTE       = 8'h06;
    localparam logic [7:0] C_NAK_BYTE       = 8'h15;
    localparam logic [7:0] C_CMD_WR_DEF     = 8'hA5;
    localparam logic [7:0] C_CMD_RD_DEF     = 8'h5A;
    localparam int         C_HDR_LEN        = 4;
    localparam int         C_BYTES_PER_WORD = 4;

    // States in which an idle rx line counts towards the frame timeout.
    function automatic logic is_timed(input state_e s);
        return (s == ST_HDR) || (s == ST_WR_COLLECT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/con_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : con_byte_packer
// Description : Little-endian 4-byte <-> 32-bit word shifter with byte index.
// Revision    : 1.0 - initial release
// ============================================================================
module con_byte_packer
    import con_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        push_i,
    input  logic [7:0]  push_byte_i,
    input  logic        load_i,
    input  logic [31:0] load_word_i,
    input  logic        pop_i,
    output logic [31:0] word_o,
    output logic        last_o
);

    logic [31:0] word_q;
    logic [1:0]  idx_q;

    // Bytes enter at the top and walk down, so byte 0 ends in [7:0];
    // popping shifts the same way, leaving the next byte in [15:8] beforehand.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (load_i) begin
            word_q <= load_word_i;
            idx_q  <= '0;
        end else if (push_i) begin
            word_q <= {push_byte_i, word_q[31:8]};
            idx_q  <= idx_q + 2'd1;
        end else if (pop_i) begin
            word_q <= {8'h00, word_q[31:8]};
            idx_q  <= idx_q + 2'd1;
        end else if (clr_i) begin
            idx_q  <= '0;
        end
    end

    assign word_o = word_q;
    assign last_o = (idx_q == 2'(C_BYTES_PER_WORD - 1));

endmodule
`default_nettype wire

// File: rtl/con_loader.sv
`default_nettype none
// ============================================================================
// Module      : con_loader
// Description : Framed byte-stream loader/dumper for the core console memory
//               port. Optional write readback: define CON_LOADER_VERIFY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module con_loader
    import con_loader_pkg::*;
#(
    parameter int         ADDR_W       = 10,
    parameter int         IDLE_TIMEOUT = 1023,
    parameter logic [7:0] CMD_WR       = C_CMD_WR_DEF,
    parameter logic [7:0] CMD_RD       = C_CMD_RD_DEF
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [3:0]        con_write,
    output logic [ADDR_W-1:0] con_addr,
    output logic [31:0]       con_in,
    input  logic [31:0]       con_out,
    output logic              core_hold,
    output logic              err
);

    localparam int C_TMR_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [C_TMR_W-1:0] C_TMR_LIM = C_TMR_W'(IDLE_TIMEOUT - 1);

    state_e              state_q;
    logic [1:0]          hdr_idx_q;
    logic [7:0]          addr_lo_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [15:0]         rem_q;
    logic                wr_frame_q;
    logic [C_TMR_W-1:0]  tmr_q;
    logic                rx_ready_q;
    logic                tx_valid_q;
    logic [7:0]          tx_data_q;
    logic [3:0]          con_write_q;
    logic                core_hold_q;
    logic                err_q;
`ifdef CON_LOADER_VERIFY_EN
    logic                vfy_bad_q;
    logic                vfy_bad_now;
`endif

    logic        rx_fire;
    logic        tx_fire;
    logic        timeout;
    logic [15:0] start_addr;
    logic [15:0] word_count;
    logic [31:0] pk_word;
    logic        pk_last;

    assign rx_fire    = rx_valid & rx_ready_q;
    assign tx_fire    = tx_valid_q & tx_ready;
    assign timeout    = is_timed(state_q) & ~rx_fire & (tmr_q == C_TMR_LIM);
    assign start_addr = {rx_data, addr_lo_q};
    assign word_count = {rx_data, rem_q[7:0]};
`ifdef CON_LOADER_VERIFY_EN
    assign vfy_bad_now = vfy_bad_q | (con_out != pk_word);
`endif

    con_byte_packer u_packer (
        .clk_i       (CLK),
        .rst_i       (rst),
        .clr_i       (state_q == ST_IDLE),
        .push_i      ((state_q == ST_WR_COLLECT) && rx_fire),
        .push_byte_i (rx_data),
        .load_i      (state_q == ST_RD_WAIT),
        .load_word_i (con_out),
        .pop_i       ((state_q == ST_RD_SEND) && tx_fire),
        .word_o      (pk_word),
        .last_o      (pk_last)
    );

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hdr_idx_q   <= '0;
            addr_lo_q   <= '0;
            addr_q      <= '0;
            rem_q       <= '0;
            wr_frame_q  <= 1'b0;
            tmr_q       <= '0;
            rx_ready_q  <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            con_write_q <= '0;
            core_hold_q <= 1'b0;
            err_q       <= 1'b0;
`ifdef CON_LOADER_VERIFY_EN
            vfy_bad_q   <= 1'b0;
`endif
        end else begin
            err_q <= 1'b0;
            tmr_q <= (is_timed(state_q) && !rx_fire) ? tmr_q + C_TMR_W'(1) : '0;
            if (timeout) begin
                // A partial word is simply dropped: it only ever lived in the packer.
                state_q     <= ST_IDLE;
                rx_ready_q  <= 1'b1;
                core_hold_q <= 1'b0;
                err_q       <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        rx_ready_q <= 1'b1;
                        if (rx_fire) begin
                            if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                                state_q     <= ST_HDR;
                                core_hold_q <= 1'b1;
                                wr_frame_q  <= (rx_data == CMD_WR);
                                hdr_idx_q   <= '0;
`ifdef CON_LOADER_VERIFY_EN
                                vfy_bad_q   <= 1'b0;
`endif
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    ST_HDR: if (rx_fire) begin
                        hdr_idx_q <= hdr_idx_q + 2'd1;
                        case (hdr_idx_q)
                            2'd0: addr_lo_q <= rx_data;
                            2'd1: addr_q    <= ADDR_W'(start_addr);
                            2'd2: rem_q[7:0] <= rx_data;
                            default: begin
                                rem_q[15:8] <= rx_data;
                                rx_ready_q  <= 1'b0;
                                if (word_count == 16'd0) begin
                                    state_q    <= ST_ACK;
                                    tx_valid_q <= 1'b1;
                                    tx_data_q  <= C_ACK_BYTE;
                                end else if (wr_frame_q) begin
                                    state_q    <= ST_WR_COLLECT;
                                    rx_ready_q <= 1'b1;
                                end else begin
                                    state_q    <= ST_RD_ISSUE;
                                end
                            end
                        endcase
                    end
                    ST_WR_COLLECT: if (rx_fire && pk_last) begin
                        state_q     <= ST_WR_COMMIT;
                        rx_ready_q  <= 1'b0;
                        con_write_q <= 4'hF;
                    end
                    ST_WR_COMMIT: begin
                        con_write_q <= '0;
`ifdef CON_LOADER_VERIFY_EN
                        state_q     <= ST_VFY_ISSUE;
`else
                        addr_q      <= addr_q + ADDR_W'(1);
                        rem_q       <= rem_q - 16'd1;
                        if (rem_q == 16'd1) begin
                            state_q    <= ST_ACK;
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= C_ACK_BYTE;
                        end else begin
                            state_q    <= ST_WR_COLLECT;
                            rx_ready_q <= 1'b1;
                        end
`endif
                    end
`ifdef CON_LOADER_VERIFY_EN
                    ST_VFY_ISSUE: state_q <= ST_VFY_WAIT;
                    ST_VFY_WAIT: begin
                        addr_q    <= addr_q + ADDR_W'(1);
                        rem_q     <= rem_q - 16'd1;
                        vfy_bad_q <= vfy_bad_now;
                        if (rem_q == 16'd1) begin
                            state_q    <= ST_ACK;
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= vfy_bad_now ? C_NAK_BYTE : C_ACK_BYTE;
                            err_q      <= vfy_bad_now;
                        end else begin
                            state_q    <= ST_WR_COLLECT;
                            rx_ready_q <= 1'b1;
                        end
                    end
`endif
                    ST_RD_ISSUE: state_q <= ST_RD_WAIT;
                    ST_RD_WAIT: begin
                        state_q    <= ST_RD_SEND;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= con_out[7:0];
                    end
                    ST_RD_SEND: if (tx_fire) begin
                        if (pk_last) begin
                            tx_valid_q <= 1'b0;
                            addr_q     <= addr_q + ADDR_W'(1);
                            rem_q      <= rem_q - 16'd1;
                            if (rem_q == 16'd1) begin
                                state_q     <= ST_IDLE;
                                core_hold_q <= 1'b0;
                                rx_ready_q  <= 1'b1;
                            end else begin
                                state_q     <= ST_RD_ISSUE;
                            end
                        end else begin
                            tx_data_q <= pk_word[15:8];
                        end
                    end
                    ST_ACK: if (tx_fire) begin
                        tx_valid_q  <= 1'b0;
                        state_q     <= ST_IDLE;
                        core_hold_q <= 1'b0;
                        rx_ready_q  <= 1'b1;
                    end
                    default: begin
                        state_q     <= ST_IDLE;
                        rx_ready_q  <= 1'b1;
                        tx_valid_q  <= 1'b0;
                        con_write_q <= '0;
                        core_hold_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rx_ready  = rx_ready_q;
    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    // Gated by rst so a reset landing on the commit cycle never writes memory.
    assign con_write = con_write_q & {4{~rst}};
    assign con_addr  = addr_q;
    assign con_in    = pk_word;
    assign core_hold = core_hold_q;
    assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_con_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_con_loader
// Description : Directed self-checking bench for con_loader with a BRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_con_loader;

    typedef logic [7:0] bytes_t [$];

    logic        CLK = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [3:0]  con_write;
    logic [9:0]  con_addr;
    logic [31:0] con_in;
    logic [31:0] con_out;
    logic        core_hold;
    logic        err;

    con_loader dut (
        .CLK       (CLK),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .con_write (con_write),
        .con_addr  (con_addr),
        .con_in    (con_in),
        .con_out   (con_out),
        .core_hold (core_hold),
        .err       (err)
    );

    always #5 CLK = ~CLK;

    // Synchronous-read memory behind the console port
    logic [31:0] mem [0:1023];
    logic [31:0] rd_q = '0;
    logic        corrupt = 1'b0;

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
        return r;
    endfunction

    always @(posedge CLK) begin
        if (con_write != 4'h0) mem[con_addr] <= merge(mem[con_addr], con_in, con_write);
        rd_q <= mem[con_addr];
    end
    assign con_out = corrupt ? 32'hDEADBEEF : rd_q;

    logic [7:0] tx_log [$];
    logic [9:0] wr_addr_log [$];
    logic [3:0] wr_be_log [$];
    int         n_err = 0;

    always @(negedge CLK) begin
        if (tx_valid && tx_ready) tx_log.push_back(tx_data);
        if (con_write != 4'h0) begin
            wr_addr_log.push_back(con_addr);
            wr_be_log.push_back(con_write);
        end
        if (err) n_err <= n_err + 1;
    end

    logic toggle_mode = 1'b0;
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            tx_ready = toggle_mode ? ~tx_ready : 1'b1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        k = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        do begin
            @(negedge CLK);
            k++;
        end while (!rx_ready && k < 200);
        chk("rx_accept", 32'(rx_ready), 32'd1);
        @(posedge CLK);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input bytes_t f);
        foreach (f[i]) send_byte(f[i]);
    endtask

    task automatic wait_tx(input int n, input int budget);
        int k;
        k = 0;
        while (tx_log.size() < n && k < budget) begin
            @(negedge CLK);
            k++;
        end
        chk("tx_wait", 32'(tx_log.size() >= n), 32'd1);
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_logs();
        tx_log.delete();
        wr_addr_log.delete();
        wr_be_log.delete();
    endtask

    logic [7:0] exp_rd [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    initial begin
        bytes_t fr;
        int     e0;
        int     k;

        for (int i = 0; i < 1024; i++) mem[i] = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_tx", 32'({tx_valid, tx_data}), 32'd0);
        chk("rst_con_wa", 32'({con_write, con_addr}), 32'd0);
        chk("rst_con_in", con_in, 32'd0);
        chk("rst_hold_err", 32'({core_hold, err}), 32'd0);
        rst = 1'b0;

        // Two-word write at 0x010
        clear_logs();
        send_byte(8'hA5);
        chk("hold_after_cmd", 32'(core_hold), 32'd1);
        fr = {8'h10, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        send_frame(fr);
        wait_tx(1, 300);
        chk("wr_ack", 32'(tx_log[0]), 32'h06);
        chk("wr_hold_released", 32'(core_hold), 32'd0);
        chk("wr_count", 32'(wr_addr_log.size()), 32'd2);
        chk("wr_addrs", 32'({wr_addr_log[0], wr_addr_log[1]}), 32'({10'h010, 10'h011}));
        chk("wr_be", 32'({wr_be_log[0], wr_be_log[1]}), 32'h00FF);
        chk("mem_010", mem[10'h010], 32'h44332211);
        chk("mem_011", mem[10'h011], 32'h88776655);
        chk("wr_no_err", 32'(n_err), 32'd0);

        // Read back with a stuttering sink
        clear_logs();
        toggle_mode = 1'b1;
        fr = {8'h5A, 8'h10, 8'h00, 8'h02, 8'h00};
        send_frame(fr);
        wait_tx(8, 400);
        repeat (20) @(posedge CLK);
        #1;
        toggle_mode = 1'b0;
        chk("rd_len", 32'(tx_log.size()), 32'd8);
        for (int i = 0; i < 8; i++) chk($sformatf("rd_byte%0d", i), 32'(tx_log[i]), 32'(exp_rd[i]));
        chk("rd_hold_released", 32'(core_hold), 32'd0);
        chk("rd_no_write", 32'(wr_addr_log.size()), 32'd0);

        // Address wrap 0x3FF -> 0x000
        clear_logs();
        fr = {8'hA5, 8'hFF, 8'h03, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send_frame(fr);
        wait_tx(1, 300);
        chk("wrap_ack", 32'(tx_log[0]), 32'h06);
        chk("wrap_addrs", 32'({wr_addr_log[0], wr_addr_log[1]}), 32'({10'h3FF, 10'h000}));
        chk("mem_3ff", mem[10'h3FF], 32'h04030201);
        chk("mem_000", mem[10'h000], 32'h08070605);

        // Bad command byte
        clear_logs();
        e0 = n_err;
        send_byte(8'h33);
        chk("bad_hold", 32'(core_hold), 32'd0);
        repeat (5) @(posedge CLK);
        #1;
        chk("bad_err_pulse", 32'(n_err - e0), 32'd1);
        chk("bad_no_wr_tx", 32'(wr_addr_log.size() + tx_log.size()), 32'd0);
        fr = {8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(fr);
        wait_tx(1, 100);
        chk("after_bad_ack", 32'(tx_log[0]), 32'h06);

        // Inter-byte timeout with a partial word pending
        clear_logs();
        e0 = n_err;
        fr = {8'hA5, 8'h00, 8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB};
        send_frame(fr);
        chk("to_hold_active", 32'(core_hold), 32'd1);
        k = 0;
        while (n_err == e0 && k < 1200) begin
            @(negedge CLK);
            k++;
        end
        chk("to_err_pulse", 32'(n_err - e0), 32'd1);
        chk("to_latency", 32'(k >= 1015 && k <= 1035), 32'd1);
        @(posedge CLK);
        #1;
        chk("to_hold_released", 32'(core_hold), 32'd0);
        chk("to_no_wr_tx", 32'(wr_addr_log.size() + tx_log.size()), 32'd0);
        chk("to_mem_000", mem[10'h000], 32'h08070605);
        fr = {8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(fr);
        wait_tx(1, 100);
        chk("to_n0_ack", 32'(tx_log[0]), 32'h06);
        chk("to_n0_no_wr", 32'(wr_addr_log.size()), 32'd0);

`ifdef CON_LOADER_VERIFY_EN
        // Readback mismatch must NAK
        clear_logs();
        e0 = n_err;
        corrupt = 1'b1;
        fr = {8'hA5, 8'h20, 8'h00, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        send_frame(fr);
        wait_tx(1, 300);
        corrupt = 1'b0;
        chk("vfy_nak", 32'(tx_log[0]), 32'h15);
        chk("vfy_err_pulse", 32'(n_err - e0), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
